// File: rtl/spi_slave_stream.sv
// Mode-3 SPI slave on sys_clk: oversampled sclk/mosi/cs, RX byte stream out, TX byte stream in.
// Optional sticky overflow/underrun status ports are built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_stream #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       spi_miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       frame_active_o
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic       status_clr_i,
  output logic       rx_ovf_o,
  output logic       tx_udf_o
`endif
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q[0] <= spi_clk_i;
      cs_sync_q[0]   <= spi_cs_i;
      mosi_sync_q[0] <= spi_mosi_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_fall, sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic       miso_q, miso_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  logic       edge_en, tx_fetch, rx_push;
  logic [7:0] rx_byte;

  // A CS rise suppresses any sclk edge seen in the same cycle.
  assign edge_en  = (state_q == ST_ACTIVE) && !cs_rise;
  assign tx_fetch = edge_en && sclk_fall && (bit_cnt_q == 3'd0);
  assign rx_push  = edge_en && sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte  = {rx_shift_q, mosi_s};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = 1'b1;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // Aborted frame: drop any partial byte and restart alignment.
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else begin
          miso_d = tx_shift_q[7];
          if (sclk_fall) begin
            if (bit_cnt_q == 3'd0) tx_shift_d = tx_valid_i ? tx_data_i : IDLE_TX;
            else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else if (sclk_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (rx_push && (!rx_valid_q || rx_ready_i)) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_miso_o     = miso_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign tx_ready_o     = tx_fetch;
  assign frame_active_o = (state_q == ST_ACTIVE);

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_ovf_q, tx_udf_q;
  logic rx_ovf_evt, tx_udf_evt;

  assign rx_ovf_evt = rx_push && rx_valid_q && !rx_ready_i;
  assign tx_udf_evt = tx_fetch && !tx_valid_i;

  // Sticky flags: a set event outranks a simultaneous clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
    end else begin
      if (rx_ovf_evt)        rx_ovf_q <= 1'b1;
      else if (status_clr_i) rx_ovf_q <= 1'b0;
      if (tx_udf_evt)        tx_udf_q <= 1'b1;
      else if (status_clr_i) tx_udf_q <= 1'b0;
    end
  end

  assign rx_ovf_o = rx_ovf_q;
  assign tx_udf_o = tx_udf_q;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: a bit-level mode-3 master model drives frames and
// checks the RX stream, MISO bytes and fetch strobes against hand-computed vectors.
module tb_spi_slave_stream;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       spi_clk, spi_mosi, spi_cs;
  logic       spi_miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_o;
  logic       frame_active_o;
`ifdef SPI_SLAVE_STATUS_EN
  logic       status_clr;
  logic       rx_ovf_o, tx_udf_o;
`endif

  spi_slave_stream #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .spi_clk_i      (spi_clk),
    .spi_mosi_i     (spi_mosi),
    .spi_cs_i       (spi_cs),
    .spi_miso_o     (spi_miso_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready_o),
    .frame_active_o (frame_active_o)
`ifdef SPI_SLAVE_STATUS_EN
    ,
    .status_clr_i   (status_clr),
    .rx_ovf_o       (rx_ovf_o),
    .tx_udf_o       (tx_udf_o)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor, sampled mid-cycle after stimulus has settled.
  int         hs_cnt = 0;
  int         rxv_cycles = 0;
  int         txr_cnt = 0;
  logic [7:0] hs_last = 8'h00;
  logic [7:0] hs_prev = 8'h00;

  always @(negedge sys_clk) begin
    #2;
    if (rx_valid_o && rx_ready) begin
      hs_prev = hs_last;
      hs_last = rx_data_o;
      hs_cnt++;
    end
    if (rx_valid_o) rxv_cycles++;
    if (tx_ready_o) txr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, output logic m);
    @(negedge sys_clk);
    spi_clk  = 1'b0;
    spi_mosi = b;
    repeat (6) @(negedge sys_clk);
    m       = spi_miso_o;
    spi_clk = 1'b1;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) begin
      logic bm;
      spi_bit(b[i], bm);
      m[i] = bm;
    end
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    @(negedge sys_clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] txd;
    logic       txv;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] m, m2;
    logic       bm;
    logic [7:0] pat;
    int         hs0, rv0, tr0;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[3] = '{8'h81, 8'h7E, 1'b1, 8'h81, 8'h7E};
    vecs[4] = '{8'h5A, 8'h12, 1'b0, 8'h5A, 8'hFF};

    sys_rst_n = 1'b0;
    spi_clk   = 1'b1;
    spi_mosi  = 1'b0;
    spi_cs    = 1'b1;
    rx_ready  = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b0;
`endif

    repeat (3) @(negedge sys_clk);
    check("rst_miso", spi_miso_o, 1'b1);
    check("rst_rx_data", rx_data_o, 8'h00);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_tx_ready", tx_ready_o, 1'b0);
    check("rst_frame_active", frame_active_o, 1'b0);
`ifdef SPI_SLAVE_STATUS_EN
    check("rst_rx_ovf", rx_ovf_o, 1'b0);
    check("rst_tx_udf", tx_udf_o, 1'b0);
`endif
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("idle_miso", spi_miso_o, 1'b1);

    // Single-byte frames with a ready consumer.
    for (int v = 0; v < 5; v++) begin
      hs0 = hs_cnt; rv0 = rxv_cycles; tr0 = txr_cnt;
      tx_data  = vecs[v].txd;
      tx_valid = vecs[v].txv;
      rx_ready = 1'b1;
      cs_low();
      check("frame_active_on", frame_active_o, 1'b1);
      spi_byte(vecs[v].mosi, m);
      cs_high();
      check("vec_rx_count", hs_cnt - hs0, 1);
      check("vec_rx_data", hs_last, vecs[v].exp_rx);
      check("vec_rx_valid_cycles", rxv_cycles - rv0, 1);
      check("vec_miso", m, vecs[v].exp_miso);
      check("vec_tx_ready_pulses", txr_cnt - tr0, 1);
    end
    check("frame_active_off", frame_active_o, 1'b0);

    // Overflow: consumer stalled across a 3-byte frame.
    hs0 = hs_cnt;
    rx_ready = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    cs_low();
    spi_byte(8'h01, m);
    spi_byte(8'h02, m);
    spi_byte(8'h03, m);
    cs_high();
    check("ovf_rx_data", rx_data_o, 8'h01);
    check("ovf_rx_valid", rx_valid_o, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
    check("ovf_flag_set", rx_ovf_o, 1'b1);
    check("ovf_udf_clear", tx_udf_o, 1'b0);
    status_clr = 1'b1;
    @(negedge sys_clk);
    status_clr = 1'b0;
    check("ovf_flag_cleared", rx_ovf_o, 1'b0);
`endif
    rx_ready = 1'b1;
    @(negedge sys_clk);
    check("ovf_drain_valid", rx_valid_o, 1'b0);
    #3;
    check("ovf_drain_count", hs_cnt - hs0, 1);
    check("ovf_drain_data", hs_last, 8'h01);

    // Underrun: no TX data for a 2-byte frame.
    hs0 = hs_cnt;
    tx_valid = 1'b0;
    tx_data  = 8'h55;
    cs_low();
    spi_byte(8'h11, m);
    spi_byte(8'h22, m2);
    cs_high();
    check("udf_miso0", m, 8'hFF);
    check("udf_miso1", m2, 8'hFF);
    check("udf_rx_count", hs_cnt - hs0, 2);
    check("udf_rx_last", hs_last, 8'h22);
`ifdef SPI_SLAVE_STATUS_EN
    check("udf_flag_set", tx_udf_o, 1'b1);
`endif

    // Frame aborted after 5 bits of 0xF0, then a clean 0x81 frame.
    hs0 = hs_cnt; rv0 = rxv_cycles;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    pat      = 8'hF0;
    cs_low();
    for (int i = 7; i >= 3; i--) spi_bit(pat[i], bm);
    cs_high();
    check("abort_no_rx", hs_cnt - hs0, 0);
    check("abort_no_valid", rxv_cycles - rv0, 0);
    check("abort_idle", frame_active_o, 1'b0);
    check("abort_miso_idle", spi_miso_o, 1'b1);
    cs_low();
    spi_byte(8'h81, m);
    cs_high();
    check("abort_next_count", hs_cnt - hs0, 1);
    check("abort_next_data", hs_last, 8'h81);
    check("abort_next_miso", m, 8'hC3);

    // Push coinciding with a handshake on a full holding register.
    hs0 = hs_cnt;
    rx_ready = 1'b0;
    tx_data  = 8'h00;
    pat      = 8'h93;
    cs_low();
    spi_byte(8'h6C, m);
    for (int i = 7; i >= 1; i--) spi_bit(pat[i], bm);
    @(negedge sys_clk);
    spi_clk  = 1'b0;
    spi_mosi = pat[0];
    repeat (6) @(negedge sys_clk);
    spi_clk = 1'b1;
    repeat (2) @(negedge sys_clk);
    rx_ready = 1'b1;
    @(negedge sys_clk);
    check("nobubble_valid", rx_valid_o, 1'b1);
    check("nobubble_data", rx_data_o, 8'h93);
    @(negedge sys_clk);
    check("nobubble_drained", rx_valid_o, 1'b0);
    #3;
    check("nobubble_count", hs_cnt - hs0, 2);
    check("nobubble_first", hs_prev, 8'h6C);
    check("nobubble_second", hs_last, 8'h93);
`ifdef SPI_SLAVE_STATUS_EN
    check("nobubble_no_ovf", rx_ovf_o, 1'b0);
`endif
    cs_high();

    // Asynchronous reset in the middle of a byte.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    pat      = 8'hB7;
    cs_low();
    for (int i = 7; i >= 4; i--) spi_bit(pat[i], bm);
    check("midrst_active_before", frame_active_o, 1'b1);
    check("midrst_miso_before", spi_miso_o, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    spi_clk   = 1'b1;
    spi_cs    = 1'b1;
    #1;
    check("midrst_miso", spi_miso_o, 1'b1);
    check("midrst_rx_data", rx_data_o, 8'h00);
    check("midrst_rx_valid", rx_valid_o, 1'b0);
    check("midrst_tx_ready", tx_ready_o, 1'b0);
    check("midrst_frame_active", frame_active_o, 1'b0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    hs0 = hs_cnt;
    tx_data = 8'hE1;
    cs_low();
    spi_byte(8'h5A, m);
    cs_high();
    check("postrst_count", hs_cnt - hs0, 1);
    check("postrst_data", hs_last, 8'h5A);
    check("postrst_miso", m, 8'hE1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
